// File: rtl/sram_rv.sv
// rtl/sram_rv.sv - byte-strobed SRAM with valid/ready write and read channels, 2-deep read response FIFO.
// Optional SRAM_RV_FWD_EN: same-word same-cycle read sees the write (write-first); otherwise read-first.
module sram_rv #(
  parameter int SRAM_SIZE  = 0,
  parameter int ADDR_WIDTH = 0,
  parameter int DATA_WIDTH = 0,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  berr_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerr_o
);

  localparam int SW     = (STRB_WIDTH > 0) ? STRB_WIDTH : 1;
  localparam int MEM_AW = (SRAM_SIZE > 1) ? $clog2(SRAM_SIZE) : 1;
  localparam int OFF_W  = $clog2(SW);
  localparam int IDX_W  = (MEM_AW > OFF_W) ? MEM_AW - OFF_W : 1;
  localparam int DEPTH  = (SRAM_SIZE > SW) ? SRAM_SIZE / SW : 1;

  if (SRAM_SIZE <= 0 || (SRAM_SIZE & (SRAM_SIZE - 1)) != 0) begin : g_chk_size
    $fatal(1, "sram_rv: SRAM_SIZE must be a nonzero power of two");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_chk_dw
    $fatal(1, "sram_rv: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (ADDR_WIDTH <= 0 || ADDR_WIDTH < MEM_AW) begin : g_chk_aw
    $fatal(1, "sram_rv: ADDR_WIDTH must be nonzero and cover SRAM_SIZE");
  end
  if (SRAM_SIZE < 2 * SW) begin : g_chk_depth
    $fatal(1, "sram_rv: SRAM_SIZE must hold at least two words");
  end

  logic             active_q;
  logic             w_acc, r_acc;
  logic             w_oor, r_oor;
  logic [IDX_W-1:0] w_idx, r_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  pend_q;
  logic [DATA_WIDTH-1:0] pend_data_q;
  logic                  pend_err_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_err_q  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_nxt;
  logic                  push, pop, pop_fifo;
  logic [2:0]            occ;

  logic bvalid_q, berr_q;

  assign w_idx = awaddr_i[MEM_AW-1:OFF_W];
  assign r_idx = araddr_i[MEM_AW-1:OFF_W];

  // Any set bit above the array's address span means addr >= SRAM_SIZE.
  if (ADDR_WIDTH > MEM_AW) begin : g_oor
    assign w_oor = |awaddr_i[ADDR_WIDTH-1:MEM_AW];
    assign r_oor = |araddr_i[ADDR_WIDTH-1:MEM_AW];
  end else begin : g_no_oor
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
  end

  if (OFF_W > 0) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^{awaddr_i[OFF_W-1:0], araddr_i[OFF_W-1:0]};
  end

  // Acceptance is held off for the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) active_q <= 1'b0;
    else         active_q <= 1'b1;
  end

  assign wready_o = !bvalid_q || bready_i;
  assign w_acc    = wvalid_i && wready_o && active_q;

  assign occ       = {1'b0, cnt_q} + {2'b00, pend_q};
  assign arready_o = occ < 3'd2;
  assign r_acc     = arvalid_i && arready_o && active_q;

  always_ff @(posedge clk_i) begin
    if (w_acc && !w_oor) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_i[i]) mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[r_idx];
`ifdef SRAM_RV_FWD_EN
    if (w_acc && !w_oor && (w_idx == r_idx)) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_i[i]) rd_word[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
`endif
    if (r_oor) rd_word = '0;
  end

  // Stage holding the read issued at acceptance; it drives the output directly when the FIFO is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      pend_q <= r_acc;
      if (r_acc) begin
        pend_data_q <= rd_word;
        pend_err_q  <= r_oor;
      end
    end
  end

  assign rvalid_o = (cnt_q != 2'd0) || pend_q;
  assign rdata_o  = (cnt_q != 2'd0) ? fifo_data_q[rd_ptr_q] : pend_data_q;
  assign rerr_o   = (cnt_q != 2'd0) ? fifo_err_q[rd_ptr_q]  : pend_err_q;

  assign pop      = rvalid_o && rready_i;
  assign pop_fifo = pop && (cnt_q != 2'd0);
  assign push     = pend_q && ((cnt_q != 2'd0) || !rready_i);
  assign cnt_nxt  = cnt_q + {1'b0, push} - {1'b0, pop_fifo};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= pend_data_q;
        fifo_err_q[wr_ptr_q]  <= pend_err_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid_q <= 1'b0;
      berr_q   <= 1'b0;
    end else if (w_acc) begin
      bvalid_q <= 1'b1;
      berr_q   <= w_oor;
    end else if (bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  assign bvalid_o = bvalid_q;
  assign berr_o   = berr_q;

endmodule

// File: tb/tb_sram_rv.sv
// tb/tb_sram_rv.sv - scoreboard bench for sram_rv against a byte-array reference model.
module tb_sram_rv;
  localparam int SRAM = 1024;
  localparam int AW   = 12;
  localparam int DW   = 32;
`ifdef SRAM_RV_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wvalid, wready, bvalid, bready, berr;
  logic arvalid, arready, rvalid, rready, rerr;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;

  always #5 clk = ~clk;

  sram_rv #(.SRAM_SIZE(SRAM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wvalid_i(wvalid), .wready_o(wready), .awaddr_i(awaddr), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .berr_o(berr),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rerr_o(rerr)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } rresp_t;

  logic [7:0] mm [SRAM];
  rresp_t     rq[$];
  logic       bq[$];
  int         errors = 0;
  int         checks = 0;
  bit         armed = 1'b0;
  bit         lat_pend = 1'b0;
  bit         stall_v = 1'b0;
  logic [31:0] stall_d;
  logic        stall_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rresp_t model_read(input logic [AW-1:0] a);
    rresp_t r;
    int base;
    if (int'(a) >= SRAM) return '{d: 32'h0, e: 1'b1};
    base = int'(a) / 4 * 4;
    r.d = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
    r.e = 1'b0;
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int base;
    if (int'(a) >= SRAM) return;
    base = int'(a) / 4 * 4;
    for (int i = 0; i < 4; i++) if (s[i]) mm[base+i] = d[8*i +: 8];
  endtask

  // Monitor: pops expected responses, then records this cycle's acceptances into the model.
  always @(negedge clk) begin
    rresp_t e;
    logic   eb, wa, ra;
    if (!rst_n) begin
      rq.delete();
      bq.delete();
      armed    = 1'b0;
      lat_pend = 1'b0;
      stall_v  = 1'b0;
    end else if (!armed) begin
      armed = 1'b1;
    end else begin
      if (lat_pend) chk("read_latency", rvalid, 1);
      lat_pend = 1'b0;
      if (stall_v) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", {rdata, rerr}, {stall_d, stall_e});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
        else begin
          e = rq.pop_front();
          chk("rdata", rdata, e.d);
          chk("rerr", rerr, e.e);
        end
      end
      stall_v = rvalid && !rready;
      stall_d = rdata;
      stall_e = rerr;
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
        else begin
          eb = bq.pop_front();
          chk("berr", berr, eb);
        end
      end
      wa = wvalid && wready;
      ra = arvalid && arready;
      if (FWD && wa) model_write(awaddr, wdata, wstrb);
      if (ra) begin
        lat_pend = (rq.size() == 0);
        rq.push_back(model_read(araddr));
      end
      if (!FWD && wa) model_write(awaddr, wdata, wstrb);
      if (wa) bq.push_back(int'(awaddr) >= SRAM);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok = 1'b0;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = wready;
      cyc();
    end
    chk("w_accept", ok, 1);
    wvalid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    logic ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = arready;
      cyc();
    end
    chk("r_accept", ok, 1);
    arvalid = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 15) == 0) return AW'(12'h400 + $urandom_range(0, 12'hBFF));
    return AW'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
  endfunction

  initial begin
    wvalid = 0; arvalid = 0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bready = 1; rready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wready", wready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_berr", berr, 0);
    chk("rst_arready", arready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rerr", rerr, 0);
    rst_n = 1'b1;
    cyc();

    for (int w = 0; w < SRAM / 4; w++) wr(AW'(w * 4), $urandom, 4'hF);
    repeat (3) cyc();

    wr(12'h010, 32'hDEADBEEF, 4'hF);
    rd(12'h010);
    wr(12'h010, 32'h000000AA, 4'h1);
    rd(12'h010);
    wr(12'h014, 32'h55555555, 4'h0);
    rd(12'h014);
    wr(12'h400, 32'h11111111, 4'hF);
    rd(12'h400);
    rd(12'h000);
    repeat (3) cyc();

    rready = 1'b0;
    rd(12'h000);
    rd(12'h004);
    araddr = 12'h008; arvalid = 1'b1;
    @(negedge clk);
    chk("arready_full", arready, 0);
    cyc();
    rready = 1'b1;
    rd(12'h008);
    repeat (4) cyc();

    wr(12'h020, 32'h0, 4'hF);
    awaddr = 12'h020; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h020; arvalid = 1'b1;
    @(negedge clk);
    chk("same_cycle_ready", {wready, arready}, 2'b11);
    cyc();
    wvalid = 1'b0; arvalid = 1'b0;
    repeat (3) cyc();

    for (int n = 0; n < 3000; n++) begin
      wvalid  = $urandom_range(0, 1);
      awaddr  = pick();
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      arvalid = $urandom_range(0, 1);
      araddr  = pick();
      rready  = ($urandom_range(0, 3) != 0);
      bready  = ($urandom_range(0, 3) != 0);
      cyc();
    end
    wvalid = 0; arvalid = 0; rready = 1; bready = 1;
    repeat (10) cyc();
    chk("drain_rq", rq.size(), 0);
    chk("drain_bq", bq.size(), 0);

    rready = 1'b0; bready = 1'b0;
    wr(12'h030, 32'hCAFEF00D, 4'hF);
    rd(12'h034);
    cyc();
    @(negedge clk);
    chk("pend_bvalid", bvalid, 1);
    chk("pend_rvalid", rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_bvalid", bvalid, 0);
    chk("rst_drop_rvalid", rvalid, 0);
    awaddr = 12'h030; wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    rd(12'h030);
    rd(12'h010);
    repeat (10) cyc();
    chk("final_rq", rq.size(), 0);
    chk("final_bq", bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
